// File: rtl/avalon_nn_burst_slave.sv
// avalon_nn_burst_slave: Avalon-MM burst slave mapping pixel/weight RAMs, results and CTRL/STATUS
module avalon_nn_burst_slave #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 13,
    parameter int BURST_W   = 10,
    parameter int STORE_W   = 16,
    parameter int RES_W     = 17,
    parameter int PIX_DEPTH = 196,
    parameter int WGT_DEPTH = 3920,
    parameter int RES_DEPTH = 10
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          write,
    input  logic                          read,
    input  logic                          beginbursttransfer,
    input  logic [BURST_W-1:0]            burstcount,
    input  logic [ADDR_W-1:0]             address,
    input  logic [DATA_W-1:0]             writedata,
    output logic [DATA_W-1:0]             readdata,
    output logic                          readdatavalid,
    output logic                          writeresponsevalid,
    output logic [1:0]                    response,
    output logic                          waitrequest,
    output logic [$clog2(PIX_DEPTH)-1:0]  pixel_address,
    output logic [$clog2(WGT_DEPTH)-1:0]  weight_address,
    output logic                          w_enable_pixels,
    output logic                          w_enable_weights,
    output logic [STORE_W-1:0]            store_data,
    output logic [$clog2(RES_DEPTH)-1:0]  output_address,
    input  logic [RES_W-1:0]              result_output,
    input  logic                          done_calc,
    input  logic                          overflow,
    output logic                          start_calc,
    output logic                          clear_data,
    output logic                          irq
);
    localparam int PA_W = $clog2(PIX_DEPTH);
    localparam int WA_W = $clog2(WGT_DEPTH);
    localparam int OA_W = $clog2(RES_DEPTH);
    localparam logic [ADDR_W-1:0] WB = ADDR_W'(PIX_DEPTH);
    localparam logic [ADDR_W-1:0] RB = ADDR_W'(PIX_DEPTH + WGT_DEPTH);
    localparam logic [ADDR_W-1:0] CA = ADDR_W'(PIX_DEPTH + WGT_DEPTH + RES_DEPTH);
    localparam logic [ADDR_W-1:0] SA = ADDR_W'(PIX_DEPTH + WGT_DEPTH + RES_DEPTH + 1);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;
    state_t state, next_state;

    logic [ADDR_W-1:0]  cur_addr, baddr, inc;
    logic [BURST_W-1:0] beats_left, bc_eff;
    logic [1:0]         acc, beat_resp, wr_worst;
    logic [DATA_W-1:0]  rd_val;
    logic ie, st_done, st_ovf, busy, done_prev, done_set;
    logic wbeat, rbeat, last_wr, is_pix, is_wgt, is_res, is_ctrl, is_stat, is_dec;
    logic unused_ok;

    assign unused_ok = &{1'b0, beginbursttransfer, writedata[DATA_W-1:STORE_W]};

    // The first write beat is performed straight from the command; later beats use cur_addr
    assign baddr    = state == IDLE ? address : cur_addr;
    assign inc      = &baddr ? baddr : baddr + 1'b1;
    assign bc_eff   = burstcount == '0 ? BURST_W'(1) : burstcount;
    assign wbeat    = write && state != RD;
    assign rbeat    = state == RD;
    assign last_wr  = wbeat && (state == IDLE ? bc_eff == BURST_W'(1) : beats_left == BURST_W'(1));
    assign is_pix   = baddr < WB;
    assign is_wgt   = !is_pix && baddr < RB;
    assign is_res   = baddr >= RB && baddr < CA;
    assign is_ctrl  = baddr == CA;
    assign is_stat  = baddr == SA;
    assign is_dec   = baddr > SA;
    assign done_set = done_calc && !done_prev;
    assign beat_resp = is_dec ? DECERR : (wbeat && is_res) ? SLVERR : OKAY;
    assign wr_worst  = (state == WR && acc > beat_resp) ? acc : beat_resp;
    assign rd_val = is_res  ? DATA_W'(result_output) :
                    is_ctrl ? DATA_W'({ie, 1'b0}) :
                    is_stat ? DATA_W'({busy, st_ovf, st_done}) : '0;

    always_comb begin
        next_state = state == IDLE ? (write && !last_wr ? WR : read && !write ? RD : IDLE) :
                     state == WR   ? (last_wr ? IDLE : WR) :
                                     (beats_left == BURST_W'(1) ? IDLE : RD);
        waitrequest      = state == RD;
        w_enable_pixels  = wbeat && is_pix;
        w_enable_weights = wbeat && is_wgt;
        pixel_address    = is_pix ? PA_W'(baddr) : '0;
        weight_address   = is_wgt ? WA_W'(baddr - WB) : '0;
        output_address   = is_res ? OA_W'(baddr - RB) : '0;
        store_data       = wbeat ? writedata[STORE_W-1:0] : '0;
        irq              = ie && st_done;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state              <= IDLE;
            cur_addr           <= '0;
            beats_left         <= '0;
            acc                <= OKAY;
            readdata           <= '0;
            readdatavalid      <= 1'b0;
            writeresponsevalid <= 1'b0;
            response           <= OKAY;
            start_calc         <= 1'b0;
            clear_data         <= 1'b0;
            ie                 <= 1'b0;
            st_done            <= 1'b0;
            st_ovf             <= 1'b0;
            busy               <= 1'b0;
            done_prev          <= 1'b0;
        end else begin
            state <= next_state;
            if (wbeat || rbeat) begin
                cur_addr   <= inc;
                beats_left <= (state == IDLE ? bc_eff : beats_left) - 1'b1;
            end else if (state == IDLE && read) begin
                cur_addr   <= address;
                beats_left <= bc_eff;
            end
            if (wbeat) acc <= wr_worst;
            readdata           <= rbeat ? rd_val : '0;
            readdatavalid      <= rbeat;
            writeresponsevalid <= last_wr;
            response           <= last_wr ? wr_worst : rbeat ? beat_resp : OKAY;
            start_calc         <= wbeat && is_ctrl && writedata[3];
            clear_data         <= wbeat && is_ctrl && writedata[0];
            if (wbeat && is_ctrl) ie <= writedata[1];
            // Sticky status bits: a new set event beats a simultaneous write-1-to-clear
            done_prev <= done_calc;
            st_done   <= done_set || (st_done && !(wbeat && is_stat && writedata[0]));
            st_ovf    <= overflow || (st_ovf && !(wbeat && is_stat && writedata[1]));
            busy      <= start_calc || (busy && !done_set);
        end
    end
endmodule

// File: tb/tb_avalon_nn_burst_slave.sv
// tb_avalon_nn_burst_slave: directed scenario tests for the Avalon NN burst slave
module tb_avalon_nn_burst_slave;
    localparam logic [12:0] RB = 13'd4116, CA = 13'd4126, SA = 13'd4127;

    logic        clk = 1'b0, n_rst = 1'b0;
    logic        write = 1'b0, read = 1'b0, beginbursttransfer = 1'b0;
    logic [9:0]  burstcount = '0;
    logic [12:0] address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        readdatavalid, writeresponsevalid, waitrequest;
    logic [1:0]  response;
    logic [7:0]  pixel_address;
    logic [11:0] weight_address;
    logic        w_enable_pixels, w_enable_weights;
    logic [15:0] store_data;
    logic [3:0]  output_address;
    logic [16:0] result_output;
    logic        done_calc = 1'b0, overflow = 1'b0;
    logic        start_calc, clear_data, irq;

    int n_cmp = 0, n_bad = 0;

    avalon_nn_burst_slave dut (
        .clk(clk), .n_rst(n_rst), .write(write), .read(read),
        .beginbursttransfer(beginbursttransfer), .burstcount(burstcount), .address(address),
        .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
        .writeresponsevalid(writeresponsevalid), .response(response), .waitrequest(waitrequest),
        .pixel_address(pixel_address), .weight_address(weight_address),
        .w_enable_pixels(w_enable_pixels), .w_enable_weights(w_enable_weights),
        .store_data(store_data), .output_address(output_address), .result_output(result_output),
        .done_calc(done_calc), .overflow(overflow), .start_calc(start_calc),
        .clear_data(clear_data), .irq(irq)
    );

    always #5 clk = ~clk;

    // Result memory stand-in: word k holds 100+k
    assign result_output = 17'(output_address) + 17'd100;

    task automatic read1(input logic [12:0] a, output logic [31:0] d, output logic [1:0] r);
        d = 'x;
        r = 'x;
        @(negedge clk); read = 1'b1; address = a; burstcount = 10'd1;
        @(negedge clk); read = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (readdatavalid) begin
                d = readdata;
                r = response;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic write1(input logic [12:0] a, input logic [31:0] wd, output logic v, output logic [1:0] r);
        @(negedge clk); write = 1'b1; address = a; burstcount = 10'd1; writedata = wd;
        @(negedge clk); write = 1'b0;
        v = writeresponsevalid;
        r = response;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [1:0]  r;
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({readdata, readdatavalid, writeresponsevalid, response, waitrequest, w_enable_pixels,
             w_enable_weights, store_data, start_calc, clear_data, irq} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rd=%h rdv=%b wrv=%b resp=%b wait=%b wp=%b ww=%b sd=%h st=%b cl=%b irq=%b, want all 0",
                     readdata, readdatavalid, writeresponsevalid, response, waitrequest, w_enable_pixels,
                     w_enable_weights, store_data, start_calc, clear_data, irq);
        end
        n_rst = 1'b1;
        read1(CA, d, r);
        n_cmp++;
        if ({d, r} !== {32'h0, 2'b00}) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %h/%b want 0/00", d, r);
        end
        read1(SA, d, r);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_status: got %h want 0", d);
        end
    endtask

    task automatic test_pixel_burst;
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin address = 13'd0; burstcount = 10'd4; end
            write = 1'b1;
            writedata = 32'(i + 1);
            #1;
            n_cmp++;
            if ({w_enable_pixels, w_enable_weights, pixel_address, store_data} !== {2'b10, 8'(i), 16'(i + 1)}) begin
                n_bad++;
                $display("FAIL pix_beat%0d: got wp=%b ww=%b pa=%0d sd=%0d want wp=1 ww=0 pa=%0d sd=%0d",
                         i, w_enable_pixels, w_enable_weights, pixel_address, store_data, i, i + 1);
            end
            if (i == 1) begin
                @(negedge clk); write = 1'b0; #1;
                n_cmp++;
                if ({w_enable_pixels, writeresponsevalid} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL pix_idle: got wp=%b wrv=%b want 0 0", w_enable_pixels, writeresponsevalid);
                end
            end
        end
        @(negedge clk); write = 1'b0;
        n_cmp++;
        if ({writeresponsevalid, response} !== 3'b100) begin
            n_bad++;
            $display("FAIL pix_resp: got wrv=%b resp=%b want 1 00", writeresponsevalid, response);
        end
        repeat (3) begin
            @(negedge clk);
            if (writeresponsevalid) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL pix_extra_resp: got %0d extra pulses want 0", pulses);
        end
    endtask

    task automatic test_cross_burst;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin address = 13'd194; burstcount = 10'd4; end
            write = 1'b1;
            writedata = 32'h10 + 32'(i);
            #1;
            n_cmp++;
            if (i < 2 ? ({w_enable_pixels, w_enable_weights, pixel_address} !== {2'b10, 8'(194 + i)})
                      : ({w_enable_pixels, w_enable_weights, weight_address} !== {2'b01, 12'(i - 2)})) begin
                n_bad++;
                $display("FAIL cross_beat%0d: got wp=%b ww=%b pa=%0d wa=%0d", i, w_enable_pixels,
                         w_enable_weights, pixel_address, weight_address);
            end
        end
        @(negedge clk); write = 1'b0;
        n_cmp++;
        if ({writeresponsevalid, response} !== 3'b100) begin
            n_bad++;
            $display("FAIL cross_resp: got wrv=%b resp=%b want 1 00", writeresponsevalid, response);
        end
    endtask

    task automatic test_read_burst;
        int n = 0, wcnt = 0;
        @(negedge clk); read = 1'b1; address = RB; burstcount = 10'd10; #1;
        n_cmp++;
        if (waitrequest !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_accept_wait: got %b want 0", waitrequest);
        end
        @(negedge clk); read = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (waitrequest) wcnt++;
            if (readdatavalid) begin
                n_cmp++;
                if ({readdata, response} !== {32'(100 + n), 2'b00}) begin
                    n_bad++;
                    $display("FAIL rd_beat%0d: got %0d/%b want %0d/00", n, readdata, response, 100 + n);
                end
                n++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (n != 10 || wcnt != 10) begin
            n_bad++;
            $display("FAIL rd_counts: got beats=%0d wait_cycles=%0d want 10 10", n, wcnt);
        end
    endtask

    task automatic test_ctrl_status;
        logic [31:0] d;
        logic [1:0]  r;
        logic        v;
        write1(CA, 32'h0A, v, r);
        n_cmp++;
        if ({start_calc, clear_data, v, r} !== 5'b10100) begin
            n_bad++;
            $display("FAIL start_pulse: got st=%b cl=%b wrv=%b resp=%b want 1 0 1 00", start_calc, clear_data, v, r);
        end
        @(negedge clk);
        n_cmp++;
        if (start_calc !== 1'b0) begin
            n_bad++;
            $display("FAIL start_width: got %b want 0", start_calc);
        end
        read1(CA, d, r);
        n_cmp++;
        if (d !== 32'h2) begin n_bad++; $display("FAIL ctrl_readback: got %h want 2", d); end
        read1(SA, d, r);
        n_cmp++;
        if (d !== 32'h4) begin n_bad++; $display("FAIL busy_set: got %h want 4", d); end
        @(negedge clk); done_calc = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set: got %b want 1", irq); end
        read1(SA, d, r);
        n_cmp++;
        if (d !== 32'h1) begin n_bad++; $display("FAIL done_set: got %h want 1", d); end
        write1(SA, 32'h1, v, r);
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b want 0", irq); end
        read1(SA, d, r);
        n_cmp++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL done_w1c: got %h want 0", d); end
        done_calc = 1'b0;
        write1(CA, 32'h0A, v, r);
        write1(CA, 32'h0A, v, r);
        n_cmp++;
        if (start_calc !== 1'b1) begin n_bad++; $display("FAIL start_busy_pulse: got %b want 1", start_calc); end
        read1(SA, d, r);
        n_cmp++;
        if (d !== 32'h4) begin n_bad++; $display("FAIL start_busy_status: got %h want 4", d); end
        write1(CA, 32'h3, v, r);
        n_cmp++;
        if ({clear_data, start_calc} !== 2'b10) begin
            n_bad++;
            $display("FAIL clear_pulse: got cl=%b st=%b want 1 0", clear_data, start_calc);
        end
        read1(CA, d, r);
        n_cmp++;
        if (d !== 32'h2) begin n_bad++; $display("FAIL clear_selfclear: got %h want 2", d); end
        overflow = 1'b1;
        write1(SA, 32'h2, v, r);
        overflow = 1'b0;
        read1(SA, d, r);
        n_cmp++;
        if (d !== 32'h6) begin n_bad++; $display("FAIL ovf_set_wins: got %h want 6", d); end
        write1(SA, 32'h2, v, r);
        read1(SA, d, r);
        n_cmp++;
        if (d !== 32'h4) begin n_bad++; $display("FAIL ovf_w1c: got %h want 4", d); end
        @(negedge clk); done_calc = 1'b1;
        @(negedge clk); done_calc = 1'b0;
        read1(SA, d, r);
        n_cmp++;
        if (d !== 32'h1) begin n_bad++; $display("FAIL busy_cleared_by_done: got %h want 1", d); end
        write1(SA, 32'h1, v, r);
    endtask

    task automatic test_errors;
        logic [31:0] d;
        logic [1:0]  r;
        logic        v;
        @(negedge clk); write = 1'b1; address = SA; burstcount = 10'd2; writedata = 32'h0;
        @(negedge clk);
        @(negedge clk); write = 1'b0;
        n_cmp++;
        if ({writeresponsevalid, response} !== 3'b111) begin
            n_bad++;
            $display("FAIL stat_burst_decerr: got wrv=%b resp=%b want 1 11", writeresponsevalid, response);
        end
        read1(13'h1FFF, d, r);
        n_cmp++;
        if ({d, r} !== {32'h0, 2'b11}) begin n_bad++; $display("FAIL read_top_decerr: got %h/%b want 0/11", d, r); end
        write1(RB, 32'h5, v, r);
        n_cmp++;
        if ({v, r} !== 3'b110) begin n_bad++; $display("FAIL result_write_slverr: got %b/%b want 1/10", v, r); end
        read1(13'd7, d, r);
        n_cmp++;
        if ({d, r} !== {32'h0, 2'b00}) begin n_bad++; $display("FAIL pixel_read: got %h/%b want 0/00", d, r); end
        @(negedge clk); write = 1'b1; address = 13'd5; burstcount = 10'd0; writedata = 32'h55; #1;
        n_cmp++;
        if ({w_enable_pixels, pixel_address} !== {1'b1, 8'd5}) begin
            n_bad++;
            $display("FAIL zero_count_beat: got wp=%b pa=%0d want 1 5", w_enable_pixels, pixel_address);
        end
        @(negedge clk); write = 1'b0;
        n_cmp++;
        if ({writeresponsevalid, response} !== 3'b100) begin
            n_bad++;
            $display("FAIL zero_count_resp: got wrv=%b resp=%b want 1 00", writeresponsevalid, response);
        end
    endtask

    task automatic test_reset_mid_read;
        logic [31:0] d;
        logic [1:0]  r;
        logic        v;
        int cnt = 0;
        write1(CA, 32'h2, v, r);
        @(negedge clk); read = 1'b1; address = 13'd0; burstcount = 10'd8;
        @(negedge clk); read = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (readdatavalid) cnt++;
        end
        n_cmp++;
        if (cnt != 3) begin n_bad++; $display("FAIL mid_pre_beats: got %0d want 3", cnt); end
        n_rst = 1'b0; #1;
        n_cmp++;
        if ({waitrequest, readdatavalid} !== 2'b00) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got wait=%b rdv=%b want 0 0", waitrequest, readdatavalid);
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (readdatavalid) cnt++;
        end
        n_cmp++;
        if (cnt != 0) begin n_bad++; $display("FAIL mid_post_beats: got %0d want 0", cnt); end
        read1(CA, d, r);
        n_cmp++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL mid_ctrl_cleared: got %h want 0", d); end
    endtask

    initial begin
        test_reset;
        test_pixel_burst;
        test_cross_burst;
        test_read_burst;
        test_ctrl_status;
        test_errors;
        test_reset_mid_read;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
